stack_unit_p: RTL
=================

# stack_unit_p

Parametrised hardware LIFO stack for the 4-bit SAP-style CPU datapath, replacing the fixed RAM-resident push/pop path used by the B register and program counter. It holds DEPTH words of DATA_W bits, performs push, pop, simultaneous push+pop and clear in one cycle, and reports occupancy and sticky overflow/underflow status to the flag logic. A WRAP mode turns the stack into a circular history buffer that overwrites the oldest entry instead of rejecting a push when full.

## Interface
- DATA_W, 4, word width of each stack entry.
- DEPTH, 8, number of entries; any value ≥ 2, not required to be a power of two.
- WRAP, 0, 0 = reject push when full; 1 = overwrite oldest entry when full.
- CNT_W, $clog2(DEPTH+1), derived; width of `count`.
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of pointer, count and sticky flags.
- push  in  1  push `din` this cycle.
- pop  in  1  pop top entry this cycle.
- din  in  DATA_W  data to push.
- dout  out  DATA_W  registered popped word.
- dout_valid  out  1  high for exactly one cycle after an accepted pop.
- top  out  DATA_W  combinational peek of current top entry; 0 when empty.
- count  out  CNT_W  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow flag.

## Operation
- Storage: DEPTH×DATA_W array, write pointer `wp` (0..DEPTH-1, wraps modulo DEPTH), and `count`. Top index = (wp-1) mod DEPTH.
- Priority per cycle: clr > push+pop > push > pop > idle.
- clr: wp←0, count←0, ovf←0, unf←0, dout_valid←0; dout holds its value; array contents are not cleared.
- Push only, not full: mem[wp]←din, wp←wp+1, count←count+1.
- Push only, full, WRAP=0: push discarded, state unchanged, ovf←1.
- Push only, full, WRAP=1: mem[wp]←din, wp←wp+1, count stays DEPTH (oldest entry lost), ovf←1.
- Pop only, not empty: dout←mem[top], dout_valid←1, wp←wp-1, count←count-1.
- Pop only, empty: rejected, unf←1, dout unchanged, dout_valid←0, wp/count unchanged.
- Push+pop, not empty: dout←old top, dout_valid←1, mem[top]←din (replace), wp and count unchanged; no ovf even if full.
- Push+pop, empty: pass-through, dout←din, dout_valid←1, count stays 0, no unf.
- Idle: dout_valid←0; all other state held.
- ovf/unf are sticky until clr or reset.
- Unwritten entries are never exposed: top is forced to 0 when count == 0.

## Timing
- Reset (reset=0, asynchronous): wp=0, count=0, dout=0, dout_valid=0, ovf=0, unf=0; empty=1, full=0, top=0. Array contents undefined and not required to reset.
- Release of reset is synchronised by the integrator; the block samples inputs starting with the first rising edge after reset goes high.
- Pop latency: 1 cycle; dout/dout_valid valid after the edge that accepts the pop.
- count, empty, full, top reflect the new state after the same edge; empty/full are combinational from count.
- Back-to-back pushes or pops are accepted every cycle; no stall or ready signal.
- Reset asserted mid-sequence aborts the operation; no partial write survives in the pointer/count state.

## Test plan
- Reset then idle: DATA_W=4, DEPTH=4 -> count=0, empty=1, full=0, dout=0, dout_valid=0, top=0, ovf=unf=0.
- Push 0xA, push 0xB, pop, pop -> dout=0xB then 0xA, each with one-cycle dout_valid; count 1,2,1,0; empty=1 at end.
- WRAP=0, DEPTH=4: push 1,2,3,4,5 -> full=1 after 4th, 5th rejected, ovf=1, count=4; four pops return 4,3,2,1; fifth pop -> unf=1, dout stays 1, dout_valid=0.
- WRAP=1, DEPTH=4: push 1..6 -> count=4, ovf=1; pops return 6,5,4,3.
- Simultaneous push 0x7 + pop on stack [0xA,0xB] -> dout=0xB, count=2, top=0x7; push 0x5 + pop on empty stack -> dout=0x5, dout_valid=1, count=0, unf=0.
- clr with push asserted on a stack holding 3 entries with ovf=1 -> count=0, ovf=0, push ignored; reset asserted between two pushes -> count=0, dout=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/stack_unit_p.sv
// LIFO stack: push, pop, push+pop replace and clear in one cycle, with sticky ovf/unf status.
// Latency: popped word is registered on dout one cycle after the pop; top/count/empty/full follow the same edge.
// Backpressure: none. A push while full is dropped, or overwrites the oldest entry when WRAP=1. A pop while empty is dropped.
module stack_unit_p #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int WRAP   = 0,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [DATA_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  wp_inc;
    logic [PTR_W-1:0]  top_idx;
    logic              push_ok;

    // Explicit wrap so a DEPTH that is not a power of two still cycles correctly.
    assign wp_inc  = (wp == LAST_IDX) ? '0 : wp + PTR_W'(1);
    assign top_idx = (wp == '0) ? LAST_IDX : wp - PTR_W'(1);

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign top   = empty ? '0 : mem[top_idx];

    assign push_ok = !full || (WRAP != 0);

    // The array is not reset; empty masks any stale or unwritten entries.
    always_ff @(posedge clk) begin
        if (!clr && push) begin
            if (pop) begin
                if (!empty) mem[top_idx] <= din;
            end else if (push_ok) begin
                mem[wp] <= din;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp         <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ovf        <= 1'b0;
            unf        <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            if (clr) begin
                wp    <= '0;
                count <= '0;
                ovf   <= 1'b0;
                unf   <= 1'b0;
            end else if (push && pop) begin
                // Replace the top entry; an empty stack passes din straight through.
                dout       <= empty ? din : mem[top_idx];
                dout_valid <= 1'b1;
            end else if (push) begin
                if (!full) begin
                    wp    <= wp_inc;
                    count <= count + CNT_W'(1);
                end else begin
                    ovf <= 1'b1;
                    if (WRAP != 0) wp <= wp_inc;
                end
            end else if (pop) begin
                if (!empty) begin
                    dout       <= mem[top_idx];
                    dout_valid <= 1'b1;
                    wp         <= top_idx;
                    count      <= count - CNT_W'(1);
                end else begin
                    unf <= 1'b1;
                end
            end
        end
    end
endmodule
